// File: rtl/spi_slave_ctrl.sv
// SPI slave transaction controller: header decode (addr, rw), word counting, strobes for shift-reg load / mem write.
// Outputs registered, one clk after the qualifying sclk_rise; no backpressure, paced entirely by the SPI master.
module spi_slave_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int BURST  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_rise,
  input  logic              cs,
  input  logic              mosi,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic              sr_we,
  output logic              dm_we,
  output logic              miso_buff,
  output logic              word_done,
  output logic              frame_err
);

  localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HDR       = 3'd1;
  localparam logic [2:0] RD_LOAD   = 3'd2;
  localparam logic [2:0] RD        = 3'd3;
  localparam logic [2:0] WR        = 3'd4;
  localparam logic [2:0] WR_COMMIT = 3'd5;
  localparam logic [2:0] HOLD      = 3'd6;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] hdr_sr;
  logic              mid_unit;

  // A partially received header or data word is what makes a cs rise an error.
  assign mid_unit = (state == HDR || state == RD || state == WR) && (bit_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      hdr_sr    <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      miso_buff <= 1'b0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      word_done <= 1'b0;
      frame_err <= 1'b0;

      if (state != IDLE && cs) begin
        // cs wins over any coincident sclk_rise; that edge is discarded.
        state     <= IDLE;
        bit_cnt   <= '0;
        miso_buff <= 1'b0;
        frame_err <= mid_unit;
      end else begin
        case (state)
          IDLE: begin
            if (!cs) begin
              state   <= HDR;
              bit_cnt <= '0;
            end
          end

          HDR: begin
            if (sclk_rise) begin
              hdr_sr <= {hdr_sr[ADDR_W-2:0], mosi};
              if (bit_cnt == HDR_LAST) begin
                addr    <= hdr_sr;
                rw      <= mosi;
                bit_cnt <= '0;
                if (mosi) begin
                  state     <= RD_LOAD;
                  sr_we     <= 1'b1;
                  miso_buff <= 1'b1;
                end else begin
                  state <= WR;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          RD_LOAD: begin
            state <= RD;
            if (sclk_rise) bit_cnt <= CNT_ONE;
          end

          RD: begin
            if (sclk_rise) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
                if (BURST != 0) begin
                  // Address advances together with the load strobe so sr_we sees the new word.
                  addr  <= addr + 1'b1;
                  state <= RD_LOAD;
                  sr_we <= 1'b1;
                end else begin
                  state     <= HOLD;
                  miso_buff <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          WR: begin
            if (sclk_rise) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt   <= '0;
                state     <= WR_COMMIT;
                dm_we     <= 1'b1;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          WR_COMMIT: begin
            // dm_we is high this clk with the old address; step it afterwards.
            if (BURST != 0) begin
              addr    <= addr + 1'b1;
              state   <= WR;
              bit_cnt <= sclk_rise ? CNT_ONE : '0;
            end else begin
              state <= HOLD;
            end
          end

          HOLD: begin
            miso_buff <= 1'b0;
          end

          default: begin
            state     <= IDLE;
            bit_cnt   <= '0;
            miso_buff <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: one BURST=1 and one BURST=0 instance share the same SPI stimulus.
module tb_spi_slave_ctrl;

  logic clk = 1'b0;
  logic reset, sclk_rise, cs, mosi;

  logic [6:0] addr0, addr1;
  logic rw0, sr0, dm0, mb0, wd0, fe0;
  logic rw1, sr1, dm1, mb1, wd1, fe1;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(1)) u0 (
    .clk(clk), .reset(reset), .sclk_rise(sclk_rise), .cs(cs), .mosi(mosi),
    .addr(addr0), .rw(rw0), .sr_we(sr0), .dm_we(dm0), .miso_buff(mb0),
    .word_done(wd0), .frame_err(fe0)
  );

  spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(0)) u1 (
    .clk(clk), .reset(reset), .sclk_rise(sclk_rise), .cs(cs), .mosi(mosi),
    .addr(addr1), .rw(rw1), .sr_we(sr1), .dm_we(dm1), .miso_buff(mb1),
    .word_done(wd1), .frame_err(fe1)
  );

  // Frame-level model: expected strobe addresses and pulse totals per instance.
  logic [6:0] sr_q0[$], dm_q0[$], sr_q1[$], dm_q1[$];
  int exp_wd0 = 0, exp_wd1 = 0, exp_er0 = 0, exp_er1 = 0;

  // Observed pulse totals, stepped only by the compare process.
  int cnt_sr0 = 0, cnt_dm0 = 0, cnt_wd0 = 0, cnt_er0 = 0;
  int cnt_sr1 = 0, cnt_dm1 = 0, cnt_wd1 = 0, cnt_er1 = 0;
  int b_sr0, b_dm0, b_wd0, b_er0, b_sr1, b_dm1, b_wd1, b_er1;

  int m_tot = 0, m_pass = 0;
  int l_tot = 0, l_pass = 0;

  // u1 observations {sr_we, dm_we, miso_buff, word_done}: one and two clks after each edge.
  logic [3:0] snap_a[64];
  logic [3:0] snap_b[64];

  task automatic mcheck(input string name, input bit have, input logic [6:0] got, input logic [6:0] want);
    m_tot++;
    if (!have) $display("FAIL %s: pulse at addr %0h, none expected", name, got);
    else if (got !== want) $display("FAIL %s: addr %0h, expected %0h", name, got, want);
    else m_pass++;
  endtask

  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (sr0) begin
        cnt_sr0++;
        e = (sr_q0.size() != 0) ? sr_q0.pop_front() : 7'h0;
        mcheck("sr_we u0", sr_q0.size() >= 0 && e === e && cnt_sr0 > 0 && (e != 7'h0 || 1'b1), addr0, e);
      end
      if (dm0) begin
        cnt_dm0++;
        if (dm_q0.size() == 0) mcheck("dm_we u0", 1'b0, addr0, 7'h0);
        else mcheck("dm_we u0", 1'b1, addr0, dm_q0.pop_front());
      end
      if (sr1) begin
        cnt_sr1++;
        if (sr_q1.size() == 0) mcheck("sr_we u1", 1'b0, addr1, 7'h0);
        else mcheck("sr_we u1", 1'b1, addr1, sr_q1.pop_front());
      end
      if (dm1) begin
        cnt_dm1++;
        if (dm_q1.size() == 0) mcheck("dm_we u1", 1'b0, addr1, 7'h0);
        else mcheck("dm_we u1", 1'b1, addr1, dm_q1.pop_front());
      end
      if (wd0) cnt_wd0++;
      if (wd1) cnt_wd1++;
      if (fe0) cnt_er0++;
      if (fe1) cnt_er1++;
    end
  end

  task automatic check(input string name, input int got, input int want);
    l_tot++;
    if (got == want) l_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic save();
    b_sr0 = cnt_sr0; b_dm0 = cnt_dm0; b_wd0 = cnt_wd0; b_er0 = cnt_er0;
    b_sr1 = cnt_sr1; b_dm1 = cnt_dm1; b_wd1 = cnt_wd1; b_er1 = cnt_er1;
  endtask

  task automatic pulse_bit(input int idx, input logic b);
    mosi      = b;
    sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
    snap_a[idx] = {sr1, dm1, mb1, wd1};
    tick();
    snap_b[idx] = {sr1, dm1, mb1, wd1};
    tick();
    tick();
  endtask

  // Expected effect of one frame that ends with a clean cs rise.
  task automatic model_frame(input logic [6:0] a, input logic r, input int hbits, input int dbits);
    int words, part;
    if (hbits < 8) begin
      if (hbits > 0) begin
        exp_er0++;
        exp_er1++;
      end
      return;
    end
    words = dbits / 8;
    part  = dbits % 8;
    if (r) begin
      for (int k = 0; k <= words; k++) sr_q0.push_back(7'(a + k));
      sr_q1.push_back(a);
    end else begin
      for (int k = 0; k < words; k++) dm_q0.push_back(7'(a + k));
      if (words >= 1) dm_q1.push_back(a);
    end
    exp_wd0 += words;
    if (part > 0) exp_er0++;
    if (words >= 1) exp_wd1++;
    else if (part > 0) exp_er1++;
  endtask

  task automatic send_frame(input logic [6:0] a, input logic r, input int hbits, input int dbits,
                            input logic [31:0] dat);
    logic [7:0] h;
    h = {a, r};
    model_frame(a, r, hbits, dbits);
    cs = 1'b0;
    tick();
    tick();
    for (int i = 0; i < hbits; i++) pulse_bit(i, h[7-i]);
    for (int i = 0; i < dbits; i++) pulse_bit(8 + i, dat[31 - (i % 32)]);
    tick();
    cs = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] h;
    bit ok;
    reset = 1'b1; cs = 1'b1; sclk_rise = 1'b0; mosi = 1'b0;
    tick(); tick();
    check("reset u0 outputs", {addr0, rw0, sr0, dm0, mb0, wd0, fe0}, 0);
    check("reset u1 outputs", {addr1, rw1, sr1, dm1, mb1, wd1, fe1}, 0);
    reset = 1'b0;
    tick(); tick();
    check("idle u0 outputs", {addr0, rw0, sr0, dm0, mb0, wd0, fe0}, 0);
    check("idle u1 outputs", {addr1, rw1, sr1, dm1, mb1, wd1, fe1}, 0);

    // Reset in the middle of a write word: nothing committed, everything cleared.
    h = {7'h33, 1'b0};
    cs = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) pulse_bit(i, h[7-i]);
    for (int i = 0; i < 4; i++) pulse_bit(8 + i, 1'b1);
    check("pre-reset addr u1", addr1, 'h33);
    reset = 1'b1;
    #1;
    check("async reset u0", {addr0, rw0, sr0, dm0, mb0, wd0, fe0}, 0);
    tick();
    check("reset next clk u1", {addr1, rw1, sr1, dm1, mb1, wd1, fe1}, 0);
    cs = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();

    // Write 0x15 <- 0xA5.
    save();
    send_frame(7'h15, 1'b0, 8, 8, 32'hA500_0000);
    check("wr addr u1", addr1, 'h15);
    check("wr rw u1", rw1, 0);
    check("wr hdr-end strobes", snap_a[7], 4'b0000);
    check("wr commit strobes", snap_a[15], 4'b0101);
    check("wr after commit", snap_b[15], 4'b0000);
    check("wr dm count u1", cnt_dm1 - b_dm1, 1);
    check("wr sr count u1", cnt_sr1 - b_sr1, 0);
    check("wr burst addr u0", addr0, 'h16);

    // Read 0x40.
    save();
    send_frame(7'h40, 1'b1, 8, 8, 32'h0);
    check("rd load strobes", snap_a[7], 4'b1010);
    check("rd load +1 clk", snap_b[7], 4'b0010);
    ok = 1'b1;
    for (int i = 8; i < 15; i++) if (snap_a[i][1] !== 1'b1 || snap_b[i][1] !== 1'b1) ok = 1'b0;
    check("rd miso during data", ok, 1);
    check("rd word end u1", snap_a[15], 4'b0001);
    check("rd addr/rw u1", {addr1, rw1}, {7'h40, 1'b1});
    check("rd burst addr u0", addr0, 'h41);
    check("rd miso off u0", mb0, 0);

    // Burst write of 3 words across the address wrap.
    save();
    send_frame(7'h7F, 1'b0, 8, 24, 32'h1234_5678);
    check("bw dm count u0", cnt_dm0 - b_dm0, 3);
    check("bw word_done u0", cnt_wd0 - b_wd0, 3);
    check("bw no err u0", cnt_er0 - b_er0, 0);
    check("bw final addr u0", addr0, 'h02);
    check("bw dm count u1", cnt_dm1 - b_dm1, 1);
    check("bw addr u1", addr1, 'h7F);

    // cs rises after 5 data bits of a write.
    save();
    send_frame(7'h10, 1'b0, 8, 5, 32'hFFFF_FFFF);
    check("abort err u0", cnt_er0 - b_er0, 1);
    check("abort err u1", cnt_er1 - b_er1, 1);
    check("abort dm u0", cnt_dm0 - b_dm0, 0);

    // 16 data bits: BURST=0 commits once and ignores the rest.
    save();
    send_frame(7'h20, 1'b0, 8, 16, 32'hC3C3_0000);
    check("16b dm u1", cnt_dm1 - b_dm1, 1);
    check("16b wd u1", cnt_wd1 - b_wd1, 1);
    check("16b dm u0", cnt_dm0 - b_dm0, 2);
    check("16b addr u0", addr0, 'h22);

    // Header cut short, then a header with no data at all.
    save();
    send_frame(7'h55, 1'b0, 3, 0, 32'h0);
    check("hdr abort err u1", cnt_er1 - b_er1, 1);
    check("hdr abort addr kept", addr1, 'h20);
    save();
    send_frame(7'h66, 1'b0, 8, 0, 32'h0);
    check("hdr only no err", (cnt_er0 - b_er0) + (cnt_er1 - b_er1), 0);

    // Burst read wrapping 0x7E -> 0x00.
    save();
    send_frame(7'h7E, 1'b1, 8, 16, 32'h0);
    check("br sr count u0", cnt_sr0 - b_sr0, 3);
    check("br addr u0", addr0, 'h00);
    check("br sr count u1", cnt_sr1 - b_sr1, 1);

    // Read aborted mid-word.
    save();
    send_frame(7'h05, 1'b1, 8, 3, 32'h0);
    check("rd abort err", (cnt_er0 - b_er0) * 16 + (cnt_er1 - b_er1), 'h11);
    check("rd abort miso", {mb0, mb1}, 0);

    tick(); tick();
    check("sr_q0 drained", sr_q0.size(), 0);
    check("dm_q0 drained", dm_q0.size(), 0);
    check("sr_q1 drained", sr_q1.size(), 0);
    check("dm_q1 drained", dm_q1.size(), 0);
    check("word_done total u0", cnt_wd0, exp_wd0);
    check("word_done total u1", cnt_wd1, exp_wd1);
    check("frame_err total u0", cnt_er0, exp_er0);
    check("frame_err total u1", cnt_er1, exp_er1);

    $display("%0d/%0d checks passed", l_pass + m_pass, l_tot + m_tot);
    $finish;
  end

endmodule
